// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-port memory; data has priority.
// Optional macro ARB_STARVE_GUARD_EN lets a waiting fetch win after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ready
);

   typedef enum logic [1:0] {IDLE, I_XFER, D_XFER, DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_sel_d;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_i_rdata;
   logic [31:0] r_d_rdata;
   logic        w_grant_i;
   logic        w_grant_d;
   logic        w_i_wins;

`ifdef ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] r_starve;

   // Counts back-to-back data grants that left a fetch waiting.
   assign w_i_wins = i_req & (~d_req | (r_starve == CNT_W'(STARVE_LIMIT)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_starve <= '0;
      end else if (w_grant_i) begin
         r_starve <= '0;
      end else if (w_grant_d) begin
         r_starve <= i_req ? r_starve + CNT_W'(1) : '0;
      end
   end
`else
   assign w_i_wins = i_req & ~d_req;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_i_wins) begin
               w_grant_i = 1'b1;
               w_next    = I_XFER;
            end else if (d_req) begin
               w_grant_d = 1'b1;
               w_next    = D_XFER;
            end
         end
         I_XFER, D_XFER: begin
            if (m_ready) begin
               w_next = DONE;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Transfer attributes are frozen at the grant edge so requesters may change inputs freely.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sel_d   <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         if (w_grant_i) begin
            r_sel_d <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= i_addr;
         end
         if (w_grant_d) begin
            r_sel_d <= 1'b1;
            r_we    <= d_we;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
         end
         if (r_state == I_XFER && m_ready) begin
            r_i_rdata <= m_rdata;
         end
         if (r_state == D_XFER && m_ready && !r_we) begin
            r_d_rdata <= m_rdata;
         end
      end
   end

   assign m_req   = (r_state == I_XFER) || (r_state == D_XFER);
   assign m_we    = r_we & (r_state == D_XFER);
   assign m_addr  = r_addr;
   assign m_wdata = r_wdata;
   assign i_ack   = (r_state == DONE) & ~r_sel_d;
   assign d_ack   = (r_state == DONE) &  r_sel_d;
   assign i_rdata = r_i_rdata;
   assign d_rdata = r_d_rdata;

endmodule
